// File: rtl/scan_encoder_32x5.sv
// Serialises a 32-bit request vector into ascending 5-bit indices, one per
// valid/ready handshake, and pulses done_o once the vector is exhausted.
module scan_encoder_32x5 (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        load_i,
  input  logic [31:0] d_i,
  input  logic        ready_i,
  output logic        valid_o,
  output logic [4:0]  idx_o,
  output logic        last_o,
  output logic        busy_o,
  output logic        done_o,
  output logic [5:0]  count_o
);

  // state  | meaning
  // IDLE   | waiting for load_i; count_o holds the previous result
  // RUN    | presenting lowest pending index until the final handshake
  // FINISH | single done_o cycle, then back to IDLE
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] p_q, p_d;
  logic [5:0]  count_q, count_d;
  logic        valid_q, valid_d;
  logic [4:0]  idx_q, idx_d;
  logic        last_q, last_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [31:0] p_next;
  logic        handshake;

  function automatic logic [4:0] lsb_index(input logic [31:0] v);
    logic [4:0] r;
    r = 5'd0;
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) r = 5'(i);
    end
    return r;
  endfunction

  function automatic logic single_bit(input logic [31:0] v);
    return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
  endfunction

  assign handshake = valid_q && ready_i;
  // Clearing the lowest set bit is the same as clearing bit idx_q in RUN.
  assign p_next    = p_q & (p_q - 32'd1);

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    count_d = count_q;
    valid_d = valid_q;
    idx_d   = idx_q;
    last_d  = last_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (load_i) begin
          p_d     = d_i;
          count_d = 6'd0;
          busy_d  = 1'b1;
          if (d_i != 32'd0) begin
            state_d = RUN;
            valid_d = 1'b1;
            idx_d   = lsb_index(d_i);
            last_d  = single_bit(d_i);
          end else begin
            state_d = FINISH;
            valid_d = 1'b0;
            idx_d   = 5'd0;
            last_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end

      RUN: begin
        if (handshake) begin
          p_d     = p_next;
          count_d = count_q + 6'd1;
          if (last_q) begin
            state_d = FINISH;
            valid_d = 1'b0;
            idx_d   = 5'd0;
            last_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d   = lsb_index(p_next);
            last_d  = single_bit(p_next);
          end
        end
      end

      FINISH: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = IDLE;
        p_d     = 32'd0;
        valid_d = 1'b0;
        idx_d   = 5'd0;
        last_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      p_q     <= 32'd0;
      count_q <= 6'd0;
      valid_q <= 1'b0;
      idx_q   <= 5'd0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      count_q <= count_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign valid_o = valid_q;
  assign idx_o   = idx_q;
  assign last_o  = last_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign count_o = count_q;

endmodule

// File: tb/tb_scan_encoder_32x5.sv
// Directed bench for scan_encoder_32x5 with hand-computed expectations.
module tb_scan_encoder_32x5;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        load_i = 1'b0;
  logic [31:0] d_i = 32'd0;
  logic        ready_i = 1'b0;
  logic        valid_o;
  logic [4:0]  idx_o;
  logic        last_o;
  logic        busy_o;
  logic        done_o;
  logic [5:0]  count_o;

  int checks = 0;
  int errors = 0;
  int done_seen;

  scan_encoder_32x5 dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .load_i  (load_i),
    .d_i     (d_i),
    .ready_i (ready_i),
    .valid_o (valid_o),
    .idx_o   (idx_o),
    .last_o  (last_o),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .count_o (count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks every output against one expected tuple.
  task automatic chk_all(input string tag, input logic v, input logic [4:0] i,
                         input logic l, input logic b, input logic dn, input logic [5:0] c);
    chk({tag, ".valid"}, 32'(valid_o), 32'(v));
    chk({tag, ".idx"},   32'(idx_o),   32'(i));
    chk({tag, ".last"},  32'(last_o),  32'(l));
    chk({tag, ".busy"},  32'(busy_o),  32'(b));
    chk({tag, ".done"},  32'(done_o),  32'(dn));
    chk({tag, ".count"}, 32'(count_o), 32'(c));
  endtask

  initial begin
    // Reset state
    step();
    chk_all("reset", 0, 0, 0, 0, 0, 0);
    reset_i = 1'b0;

    // 8000_0011 streaming with ready held high
    ready_i = 1'b1; load_i = 1'b1; d_i = 32'h8000_0011;
    step(); load_i = 1'b0; d_i = 32'd0;
    chk_all("v23_c0", 1, 0, 0, 1, 0, 0);
    step();
    chk_all("v23_c1", 1, 4, 0, 1, 0, 1);
    step();
    chk_all("v23_c2", 1, 31, 1, 1, 0, 2);
    step();
    chk_all("v23_done", 0, 0, 0, 1, 1, 3);
    step();
    chk_all("v23_idle", 0, 0, 0, 0, 0, 3);

    // Empty vector
    load_i = 1'b1; d_i = 32'd0;
    step(); load_i = 1'b0;
    chk_all("v24_done", 0, 0, 0, 1, 1, 0);
    step();
    chk_all("v24_idle", 0, 0, 0, 0, 0, 0);

    // Back-pressure then release
    ready_i = 1'b0; load_i = 1'b1; d_i = 32'h0000_0006;
    step(); load_i = 1'b0;
    chk_all("v25_hold0", 1, 1, 0, 1, 0, 0);
    step();
    chk_all("v25_hold1", 1, 1, 0, 1, 0, 0);
    step();
    chk_all("v25_hold2", 1, 1, 0, 1, 0, 0);
    ready_i = 1'b1;
    step();
    chk_all("v25_last", 1, 2, 1, 1, 0, 1);
    step();
    chk_all("v25_done", 0, 0, 0, 1, 1, 2);
    step();
    chk_all("v25_idle", 0, 0, 0, 0, 0, 2);

    // Full vector: 32 consecutive indices, count reaches 32
    load_i = 1'b1; d_i = 32'hFFFF_FFFF;
    step(); load_i = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 32; i++) begin
      chk("v26_valid", 32'(valid_o), 32'd1);
      chk("v26_idx",   32'(idx_o),   32'(i));
      chk("v26_last",  32'(last_o),  32'(i == 31));
      chk("v26_count", 32'(count_o), 32'(i));
      if (done_o) done_seen++;
      step();
    end
    chk_all("v26_done", 0, 0, 0, 1, 1, 32);
    if (done_o) done_seen++;
    step();
    chk_all("v26_idle", 0, 0, 0, 0, 0, 32);
    chk("v26_done_pulses", 32'(done_seen), 32'd1);

    // LOAD during RUN is ignored
    load_i = 1'b1; d_i = 32'h0000_00F0;
    step(); load_i = 1'b0; d_i = 32'd0;
    chk_all("v27_i4", 1, 4, 0, 1, 0, 0);
    load_i = 1'b1; d_i = 32'h0000_0001;
    step(); load_i = 1'b0; d_i = 32'd0;
    chk_all("v27_i5", 1, 5, 0, 1, 0, 1);
    step();
    chk_all("v27_i6", 1, 6, 0, 1, 0, 2);
    step();
    chk_all("v27_i7", 1, 7, 1, 1, 0, 3);
    step();
    chk_all("v27_done", 0, 0, 0, 1, 1, 4);
    step();
    chk_all("v27_idle", 0, 0, 0, 0, 0, 4);

    // Reset mid-run discards pending bits
    load_i = 1'b1; d_i = 32'h0000_0F00;
    step(); load_i = 1'b0; d_i = 32'd0;
    chk_all("v28_i8", 1, 8, 0, 1, 0, 0);
    step();
    chk_all("v28_i9", 1, 9, 0, 1, 0, 1);
    reset_i = 1'b1;
    step(); reset_i = 1'b0;
    chk_all("v28_rst", 0, 0, 0, 0, 0, 0);
    step();
    chk_all("v28_nodone", 0, 0, 0, 0, 0, 0);
    load_i = 1'b1; d_i = 32'h0000_0001;
    step(); load_i = 1'b0; d_i = 32'd0;
    chk_all("v28_reload", 1, 0, 1, 1, 0, 0);
    step();
    chk_all("v28_done", 0, 0, 0, 1, 1, 1);
    step();

    // Reset wins over a simultaneous LOAD
    reset_i = 1'b1; load_i = 1'b1; d_i = 32'h0000_0005;
    step(); reset_i = 1'b0; load_i = 1'b0; d_i = 32'd0;
    chk_all("rst_prio", 0, 0, 0, 0, 0, 0);
    step();
    chk_all("rst_prio_after", 0, 0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/scan_encoder_32x5.md
SCAN_ENCODER_32X5 -- requirements
Module: SCAN_ENCODER_32X5

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 The block SHALL have these ports:
  CLK    in   1   clock; all state updates on rising edge
  RESET  in   1   synchronous active-high reset
  LOAD   in   1   start request; samples D when accepted
  D      in   32  request vector; bit i set = index i pending
  READY  in   1   consumer accepts IDX this cycle
  VALID  out  1   IDX holds a pending index
  IDX    out  5   binary index of the lowest pending bit
  LAST   out  1   IDX is the final pending index of the current vector
  BUSY   out  1   vector in progress; LOAD ignored
  DONE   out  1   one-cycle pulse: vector fully emitted
  COUNT  out  6   indices emitted for the current/last vector (0..32)

Function
REQ-003 The block SHALL hold a 32-bit pending register P and a state in {IDLE, RUN, FINISH}.
REQ-004 In IDLE, LOAD=1 SHALL capture P<=D, clear COUNT to 0, and enter RUN if D!=0 or FINISH if D==0.
REQ-005 LOAD SHALL be ignored in RUN and FINISH; D SHALL NOT be sampled there.
REQ-006 In RUN, VALID SHALL be 1 and IDX SHALL equal the position of the least-significant set bit of P.
REQ-007 In RUN, LAST SHALL be 1 exactly when P has one bit set; otherwise 0.
REQ-008 A handshake SHALL occur on a rising edge with VALID=1 and READY=1; it SHALL clear the bit of P at IDX and increment COUNT by 1.
REQ-009 A handshake with LAST=1 SHALL move RUN to FINISH; other handshakes SHALL stay in RUN.
REQ-010 Without a handshake, P, IDX, LAST and COUNT SHALL hold unchanged (VALID not withdrawn).
REQ-011 FINISH SHALL last exactly one cycle with DONE=1, then return to IDLE.
REQ-012 BUSY SHALL be 1 in RUN and FINISH, 0 in IDLE.
REQ-013 Outside RUN, VALID and LAST SHALL be 0 and IDX SHALL be 0.
REQ-014 DONE SHALL be 0 outside FINISH.
REQ-015 Latency: LOAD accepted at edge n SHALL give VALID=1 (or DONE=1 if D==0) in the cycle after edge n.
REQ-016 Throughput SHALL be one index per cycle while READY is held 1.
REQ-017 COUNT SHALL keep its final value through FINISH and IDLE until the next accepted LOAD.
REQ-018 For D=32'hFFFF_FFFF, COUNT SHALL reach 32 without wrap; the 6-bit width SHALL NOT overflow.
REQ-019 Indices SHALL be emitted in strictly ascending order, each set bit of D exactly once.

Reset
REQ-020 RESET=1 at a rising edge SHALL force state=IDLE, P=0, COUNT=0, VALID=0, IDX=0, LAST=0, BUSY=0, DONE=0.
REQ-021 RESET SHALL take priority over LOAD and handshakes on the same edge.
REQ-022 RESET during RUN or FINISH SHALL discard pending bits, and no DONE pulse SHALL follow.

Verification
REQ-023 D=32'h8000_0011 loaded, READY=1 -> IDX 0,4,31 on three consecutive cycles, LAST only with 31, DONE next cycle, COUNT=3.
REQ-024 D=32'h0000_0000 loaded -> VALID never 1, DONE=1 in the cycle after LOAD, COUNT=0, then BUSY=0.
REQ-025 D=32'h0000_0006, READY=0 for 3 cycles then 1 -> IDX=1, VALID=1, COUNT=0 held 3 cycles, then IDX=2 with LAST=1, then DONE, COUNT=2.
REQ-026 D=32'hFFFF_FFFF, READY=1 -> IDX 0..31 on 32 consecutive cycles, LAST on 31, COUNT=32, DONE once.
REQ-027 Load D=32'h0000_00F0, LOAD=1 with D=32'h1 at RUN cycle 2 -> LOAD ignored, only 4,5,6,7 emitted.
REQ-028 RESET=1 mid-run with D=32'h0000_0F00 after IDX=9 -> next cycle all outputs 0, no DONE; a new LOAD of 32'h1 then emits IDX=0 with LAST=1.
